// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction store, PC stepping and valid/ready issue front end.
// Optional SEQ_JUMP_EN: opcode 4'hE becomes a jump consumed in FETCH.
module instr_sequencer #(
    parameter int          AW      = 4,
    parameter int          DEPTH   = 16,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [12:0]   load_data,
    input  logic          start,
    input  logic          issue_ready,
    input  logic [7:0]    alu_result,
    output logic [3:0]    Opcode,
    output logic [2:0]    Rs,
    output logic [2:0]    Rt,
    output logic [2:0]    Rd,
    output logic          issue_valid,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [7:0]    last_result,
    output logic [7:0]    issue_count
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [12:0]   ir_q, ir_d;
    logic          halted_q, halted_d;
    logic [7:0]    last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [12:0]   mem_q [DEPTH];
    logic [12:0]   fetch_word;
    logic          ctl_open;

    assign ctl_open   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign fetch_word = mem_q[pc_q];

    // The store is deliberately left out of reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (load_en && ctl_open) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    cnt_d    = '0;
                    halted_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (fetch_word[12:9] == HALT_OP) begin
                    state_d  = S_DONE;
                    halted_d = 1'b1;
`ifdef SEQ_JUMP_EN
                end else if (fetch_word[12:9] == 4'hE) begin
                    pc_d = AW'(fetch_word[5:0]);
`endif
                end else begin
                    ir_d    = fetch_word;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    last_d = alu_result;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    // The last word ends the run; pc never wraps back to 0.
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Opcode      = ir_q[12:9];
    assign Rs          = ir_q[8:6];
    assign Rt          = ir_q[5:3];
    assign Rd          = ir_q[2:0];
    assign issue_valid = (state_q == S_ISSUE);
    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign halted      = halted_q;
    assign pc          = pc_q;
    assign last_result = last_q;
    assign issue_count = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [12:0] load_data;
    logic        start;
    logic        issue_ready;
    logic [7:0]  alu_result;
    logic [3:0]  Opcode;
    logic [2:0]  Rs, Rt, Rd;
    logic        issue_valid, busy, halted;
    logic [3:0]  pc;
    logic [7:0]  last_result, issue_count;

    int checks = 0;
    int errors = 0;
    int n;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .issue_ready(issue_ready),
        .alu_result(alu_result), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .issue_valid(issue_valid), .busy(busy), .halted(halted), .pc(pc),
        .last_result(last_result), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] mkw(input logic [3:0] op, input logic [2:0] s,
                                        input logic [2:0] t, input logic [2:0] d);
        return {op, s, t, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [12:0] d);
        load_en   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    initial begin
        rst = 1'b1; load_en = 0; load_addr = 0; load_data = 0;
        start = 0; issue_ready = 0; alu_result = 0;
        @(negedge clk);
        chk("rst_valid", issue_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_count", issue_count, 0);
        chk("rst_last", last_result, 0);
        chk("rst_fields", {Opcode, Rs, Rt, Rd}, 0);
        rst = 1'b0;

        // Basic program: two issues then HALT
        load(0, mkw(4'h1, 3'd1, 3'd2, 3'd3));
        load(1, mkw(4'h2, 3'd4, 3'd5, 3'd6));
        load(2, mkw(4'hF, 3'd0, 3'd0, 3'd0));
        issue_ready = 1'b1; alu_result = 8'h5A;
        kick();
        chk("t1_fetch_busy", busy, 1);
        chk("t1_fetch_valid", issue_valid, 0);
        @(negedge clk);
        chk("t1_iss0_valid", issue_valid, 1);
        chk("t1_iss0_fields", {Opcode, Rs, Rt, Rd}, {4'h1, 3'd1, 3'd2, 3'd3});
        @(negedge clk);
        chk("t1_acc0_valid", issue_valid, 0);
        chk("t1_acc0_pc", pc, 1);
        chk("t1_acc0_last", last_result, 8'h5A);
        chk("t1_acc0_count", issue_count, 1);
        alu_result = 8'h33;
        @(negedge clk);
        chk("t1_iss1_fields", {Opcode, Rs, Rt, Rd}, {4'h2, 3'd4, 3'd5, 3'd6});
        @(negedge clk);
        @(negedge clk);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_halted", halted, 1);
        chk("t1_done_count", issue_count, 2);
        chk("t1_done_last", last_result, 8'h33);
        chk("t1_done_pc", pc, 2);

        // Backpressure on the first issue
        issue_ready = 1'b0;
        kick();
        chk("t2_restart_count", issue_count, 0);
        chk("t2_restart_halted", halted, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", issue_valid, 1);
            chk("t2_hold_fields", {Opcode, Rs, Rt, Rd}, {4'h1, 3'd1, 3'd2, 3'd3});
            chk("t2_hold_count", issue_count, 0);
            @(negedge clk);
        end
        issue_ready = 1'b1; alu_result = 8'hA1;
        @(negedge clk);
        chk("t2_acc_count", issue_count, 1);
        chk("t2_acc_last", last_result, 8'hA1);
        chk("t2_acc_valid", issue_valid, 0);
        wait_idle("t2_wait");
        chk("t2_done_count", issue_count, 2);
        chk("t2_done_halted", halted, 1);

        // load_en and start while busy are ignored
        issue_ready = 1'b0;
        kick();
        @(negedge clk);
        load_en = 1'b1; load_addr = 4'd1; load_data = mkw(4'hF, 3'd0, 3'd0, 3'd0);
        start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        chk("t5_busy_valid", issue_valid, 1);
        chk("t5_busy_pc", pc, 0);
        chk("t5_busy_fields", {Opcode, Rs, Rt, Rd}, {4'h1, 3'd1, 3'd2, 3'd3});
        issue_ready = 1'b1; alu_result = 8'h11;
        @(negedge clk);
        @(negedge clk);
        chk("t5_store_kept", {Opcode, Rs, Rt, Rd}, {4'h2, 3'd4, 3'd5, 3'd6});
        wait_idle("t5_wait");
        chk("t5_done_count", issue_count, 2);
        // Same-cycle write to addr 0 and start in DONE
        load_en = 1'b1; load_addr = 4'd0; load_data = mkw(4'h3, 3'd7, 3'd7, 3'd7);
        start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        chk("t5_rerun_count", issue_count, 0);
        chk("t5_rerun_busy", busy, 1);
        @(negedge clk);
        chk("t5_rerun_fields", {Opcode, Rs, Rt, Rd}, {4'h3, 3'd7, 3'd7, 3'd7});
        wait_idle("t5_rerun_wait");
        chk("t5_rerun_done_count", issue_count, 2);

        // Full store, no HALT: end of store terminates
        for (int i = 0; i < 16; i++) load(i, mkw(4'(i & 7), 3'(i), 3'(i >> 3), 3'(i)));
        issue_ready = 1'b1; alu_result = 8'hC3;
        kick();
        n = 0;
        for (int c = 0; c < 80 && busy; c++) begin
            if (issue_valid) begin
                chk("t3_seq", {Rt, Rd}, n);
                n++;
            end
            @(negedge clk);
        end
        chk("t3_issues", n, 16);
        chk("t3_busy", busy, 0);
        chk("t3_pc", pc, 15);
        chk("t3_halted", halted, 0);
        chk("t3_count", issue_count, 16);
        chk("t3_last", last_result, 8'hC3);
        @(negedge clk);
        @(negedge clk);
        chk("t3_no_refetch", {busy, issue_valid}, 0);

        // Reset during the second ISSUE
        kick();
        @(negedge clk);
        chk("t4_iss0_valid", issue_valid, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_iss1_fields", {Rt, Rd}, 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", issue_valid, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_pc", pc, 0);
        chk("t4_rst_count", issue_count, 0);
        chk("t4_rst_last", last_result, 0);
        chk("t4_rst_fields", {Opcode, Rs, Rt, Rd}, 0);
        @(negedge clk);
        rst = 1'b0;
        kick();
        @(negedge clk);
        chk("t4_rerun_valid", issue_valid, 1);
        chk("t4_rerun_count", issue_count, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_rerun_second", {Rt, Rd}, 1);
        chk("t4_rerun_count1", issue_count, 1);
        wait_idle("t4_wait");

        // Opcode 4'hE: jump with SEQ_JUMP_EN, ordinary issue otherwise
        load(0, mkw(4'h1, 3'd1, 3'd2, 3'd3));
        load(1, mkw(4'hE, 3'd0, 3'd0, 3'd4));
        load(2, mkw(4'hF, 3'd0, 3'd0, 3'd0));
        kick();
        @(negedge clk);
        chk("t6_first", {Opcode, Rs, Rt, Rd}, {4'h1, 3'd1, 3'd2, 3'd3});
        @(negedge clk);
        for (int c = 0; c < 20 && !issue_valid; c++) @(negedge clk);
`ifdef SEQ_JUMP_EN
        chk("t6_jump_target", {Opcode, Rt, Rd}, {4'h4, 3'd0, 3'd4});
        chk("t6_jump_pc", pc, 4);
        chk("t6_jump_count", issue_count, 1);
`else
        chk("t6_plain_e", {Opcode, Rt, Rd}, {4'hE, 3'd0, 3'd4});
        chk("t6_plain_pc", pc, 1);
        wait_idle("t6_wait");
        chk("t6_plain_count", issue_count, 2);
        chk("t6_plain_halted", halted, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
